// File: rtl/costas_phase_detector.sv
// costas_phase_detector
//   QPSK phase detector for the Costas loop. It computes
//   e = I*Q*(I^2 - Q^2) at full precision in a 4-stage valid-tagged
//   pipeline. It also runs a windowed lock detector that compares
//   sum|I^2-Q^2| against a fraction of sum(I^2+Q^2).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_data, q_data    15b signed baseband samples
//   data_valid        sample strobe (every clk or decimated)
//   pd_err            58b signed phase error, held between updates
//   err_valid         one-clk pulse when pd_err updates
//   lock              carrier-lock indicator
module costas_phase_detector #(
    parameter int WIN_LEN    = 1024,
    parameter int LOCK_SHIFT = 3,
    parameter int LOCK_WINS  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [14:0] i_data,
    input  logic signed [14:0] q_data,
    input  logic               data_valid,
    output logic signed [57:0] pd_err,
    output logic               err_valid,
    output logic               lock
);
    localparam int STAGES = 4;
    localparam int WCW    = $clog2(WIN_LEN);

    // vld_pipe[k] tags the contents of stage k. The tag bits always shift,
    // so gaps never strand a sample. Data registers load only when tagged.
    logic [STAGES:1] vld_pipe;

    logic signed [14:0] i1, q1;
    logic signed [29:0] iq2;
    logic        [28:0] ii2, qq2;
    logic signed [29:0] iq3, diff3;
    logic        [29:0] pow3;

    logic        [41:0] acc_diff, acc_pow;
    logic        [WCW-1:0] win_cnt;
    logic        [3:0]  good_cnt;

    // Products are formed in the destination width. |I*Q|, I^2 and Q^2
    // are all <= 2^28, so nothing is lost.
    logic signed [29:0] i1x, q1x, iq_full, ii_full, qq_full;
    assign i1x     = 30'(i1);
    assign q1x     = 30'(q1);
    assign iq_full = i1x * q1x;
    assign ii_full = i1x * i1x;
    assign qq_full = q1x * q1x;

    logic signed [29:0] diff_s2;
    logic        [29:0] pow_s2;
    assign diff_s2 = $signed({1'b0, ii2}) - $signed({1'b0, qq2});
    assign pow_s2  = 30'(ii2) + 30'(qq2);

    logic signed [57:0] err_full;
    assign err_full = 58'(iq3) * 58'(diff3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            i1       <= '0;
            q1       <= '0;
            iq2      <= '0;
            ii2      <= '0;
            qq2      <= '0;
            iq3      <= '0;
            diff3    <= '0;
            pow3     <= '0;
            pd_err   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], data_valid};
            if (data_valid) begin
                i1 <= i_data;
                q1 <= q_data;
            end
            if (vld_pipe[1]) begin
                iq2 <= iq_full;
                ii2 <= ii_full[28:0];
                qq2 <= qq_full[28:0];
            end
            if (vld_pipe[2]) begin
                iq3   <= iq2;
                diff3 <= diff_s2;
                pow3  <= pow_s2;
            end
            if (vld_pipe[3]) begin
                pd_err <= err_full;
            end
        end
    end

    assign err_valid = vld_pipe[STAGES];

    // Lock detector, fed from stage 3.
    logic [29:0] adiff3;
    logic [41:0] acc_diff_nxt, acc_pow_nxt;
    logic        win_last, win_good;
    logic [3:0]  good_cnt_nxt;

    always_comb begin
        adiff3       = diff3[29] ? 30'(-diff3) : 30'(diff3);
        acc_diff_nxt = acc_diff + 42'(adiff3);
        acc_pow_nxt  = acc_pow + 42'(pow3);
        win_last     = (win_cnt == WCW'(WIN_LEN - 1));
        // The closing sample is part of the compare. A zero-power window
        // gives 0 < 0, so silence never counts as good.
        win_good     = acc_diff_nxt < (acc_pow_nxt >> LOCK_SHIFT);
        good_cnt_nxt = '0;
        if (win_good) begin
            good_cnt_nxt = (good_cnt == 4'(LOCK_WINS)) ? good_cnt : good_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_diff <= '0;
            acc_pow  <= '0;
            win_cnt  <= '0;
            good_cnt <= '0;
            lock     <= 1'b0;
        end else if (vld_pipe[3]) begin
            if (win_last) begin
                acc_diff <= '0;
                acc_pow  <= '0;
                win_cnt  <= '0;
                good_cnt <= good_cnt_nxt;
                // Acquiring lock takes LOCK_WINS good windows in a row.
                // A single bad window drops it.
                lock     <= (good_cnt_nxt == 4'(LOCK_WINS));
            end else begin
                acc_diff <= acc_diff_nxt;
                acc_pow  <= acc_pow_nxt;
                win_cnt  <= win_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_costas_phase_detector.sv
// Self-checking bench for costas_phase_detector. The reference model
// computes the error law and the lock windows in plain integer arithmetic.
// Expected outputs wait in queues and are matched against err_valid pulses.
module tb_costas_phase_detector;
    localparam int WIN_LEN    = 1024;
    localparam int LOCK_SHIFT = 3;
    localparam int LOCK_WINS  = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [14:0] i_data = '0;
    logic signed [14:0] q_data = '0;
    logic               data_valid = 1'b0;
    logic signed [57:0] pd_err;
    logic               err_valid;
    logic               lock;

    costas_phase_detector #(
        .WIN_LEN(WIN_LEN), .LOCK_SHIFT(LOCK_SHIFT), .LOCK_WINS(LOCK_WINS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .q_data(q_data),
        .data_valid(data_valid), .pd_err(pd_err), .err_valid(err_valid),
        .lock(lock)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model state.
    longint exp_err_q[$];
    bit     exp_lock_q[$];
    longint exp_cyc_q[$];
    int     m_wc;
    longint m_ad, m_ap;
    int     m_gc;
    bit     m_lock;
    int     n_sent, n_out;

    task automatic model_reset();
        exp_err_q.delete(); exp_lock_q.delete(); exp_cyc_q.delete();
        m_wc = 0; m_ad = 0; m_ap = 0; m_gc = 0; m_lock = 0;
    endtask

    task automatic model_push(input longint i, input longint q, input longint stamp);
        longint d, p;
        d = i*i - q*q;
        p = i*i + q*q;
        m_ad += (d < 0) ? -d : d;
        m_ap += p;
        m_wc++;
        if (m_wc == WIN_LEN) begin
            if (m_ad < (m_ap >>> LOCK_SHIFT)) m_gc = (m_gc < LOCK_WINS) ? m_gc + 1 : LOCK_WINS;
            else m_gc = 0;
            m_lock = (m_gc == LOCK_WINS);
            m_wc = 0; m_ad = 0; m_ap = 0;
        end
        exp_err_q.push_back(i * q * d);
        exp_lock_q.push_back(m_lock);
        exp_cyc_q.push_back(stamp);
    endtask

    // Output monitor: every err_valid pulse must match the next model entry
    // and must arrive exactly 4 clocks after its input.
    always @(negedge clk) begin
        if (rst_n && err_valid) begin
            n_out++;
            if (exp_err_q.size() == 0) begin
                chk("unexpected_err_valid", 1, 0);
            end else begin
                chk("pd_err", longint'(pd_err), exp_err_q.pop_front());
                chk("lock", longint'(lock), longint'(exp_lock_q.pop_front()));
                chk("latency", cyc - exp_cyc_q.pop_front(), 4);
            end
        end
    end

    task automatic send(input logic signed [14:0] i, input logic signed [14:0] q);
        @(negedge clk);
        i_data = i; q_data = q; data_valid = 1'b1;
        n_sent++;
        model_push(longint'(i), longint'(q), cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            data_valid = 1'b0;
            i_data = 15'($urandom);
            q_data = 15'($urandom);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && exp_err_q.size() > 0; k++) idle(1);
        idle(1);
        if (exp_err_q.size() > 0) begin
            chk("drain_timeout", longint'(exp_err_q.size()), 0);
            model_reset();
        end
    endtask

    initial begin
        model_reset();
        n_sent = 0; n_out = 0;
        repeat (3) @(negedge clk);
        chk("rst_pd_err", longint'(pd_err), 0);
        chk("rst_err_valid", longint'(err_valid), 0);
        chk("rst_lock", longint'(lock), 0);
        @(negedge clk) rst_n = 1'b1;
        idle(2);

        // Directed error-law points
        send(15'sd1000, 15'sd500);
        drain();
        chk("pos_err", longint'(pd_err), 64'sd375000000000);
        send(15'sd500, 15'sd1000);
        drain();
        chk("neg_err", longint'(pd_err), -64'sd375000000000);
        for (int k = 0; k < 20; k++) begin
            idle(1);
            chk("hold_err", longint'(pd_err), -64'sd375000000000);
            chk("hold_valid", longint'(err_valid), 0);
        end

        send(-15'sd16384, 15'sd16383);
        drain();
        chk("ext_min_max", longint'(pd_err), -64'sd8795287732224);
        send(-15'sd16384, -15'sd16384);
        drain();
        chk("ext_equal", longint'(pd_err), 0);
        send(15'sd1000, 15'sd0);
        drain();
        chk("q_zero", longint'(pd_err), 0);

        // Random stream, continuous
        for (int k = 0; k < 300; k++) send(15'($urandom), 15'($urandom));
        drain();
        // Random stream with gaps
        for (int k = 0; k < 300; k++) begin
            send(15'($urandom), 15'($urandom));
            if ($urandom_range(1, 0) == 1) idle($urandom_range(3, 1));
        end
        drain();
        chk("valid_count", longint'(n_out), longint'(n_sent));

        // Reset with three samples in flight
        send(15'sd1200, 15'sd300);
        send(15'sd700, -15'sd900);
        send(-15'sd50, 15'sd4000);
        @(negedge clk);
        rst_n = 1'b0;
        data_valid = 1'b0;
        #1;
        chk("midrst_pd_err", longint'(pd_err), 0);
        chk("midrst_valid", longint'(err_valid), 0);
        chk("midrst_lock", longint'(lock), 0);
        model_reset();
        idle(3);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            idle(1);
            chk("post_rst_quiet", longint'(err_valid), 0);
        end
        send(15'sd1000, 15'sd500);
        drain();
        chk("post_rst_err", longint'(pd_err), 64'sd375000000000);
        // Start a fresh reset so the window count begins exactly at sample 0.
        @(negedge clk) rst_n = 1'b0;
        model_reset();
        @(negedge clk) rst_n = 1'b1;

        // Lock acquire: 4 good windows
        for (int k = 0; k < 4 * WIN_LEN; k++) send(15'sd1000, 15'sd1000);
        drain();
        chk("lock_acquired", longint'(lock), 1);
        // One bad window drops lock
        for (int k = 0; k < WIN_LEN; k++) send(15'sd1000, 15'sd0);
        drain();
        chk("lock_dropped", longint'(lock), 0);
        // Silence never locks
        for (int k = 0; k < 8 * WIN_LEN; k++) send(15'sd0, 15'sd0);
        drain();
        chk("silence_nolock", longint'(lock), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/costas_phase_detector.md
Name: costas_phase_detector

Overview:
- Upstream stage of the Costas-loop filter: turns low-pass-filtered I/Q baseband samples into the 58-bit signed QPSK phase error that the loop filter consumes.
- Error law: e = I*Q*(I^2 - Q^2), pipelined, exact at full precision with no truncation.
- Output is held between samples, so the loop filter can run every clk.
- Also provides a windowed lock indicator used by the demodulator control.

Parameters:
- WIN_LEN, 1024: valid samples per lock-measurement window (power of 2, 16..4096).
- LOCK_SHIFT, 3: lock test threshold; a window is "good" when acc_diff < (acc_pow >> LOCK_SHIFT).
- LOCK_WINS, 4: consecutive good windows required to assert lock (1..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_data  in  15  signed I sample from the I-arm low-pass filter
- q_data  in  15  signed Q sample from the Q-arm low-pass filter
- data_valid  in  1  sample strobe; may be high every clk or decimated
- pd_err  out  58  signed phase error to the loop filter; held between updates
- err_valid  out  1  one-clk pulse when pd_err updates
- lock  out  1  carrier-lock indicator

Behaviour:
- Reset (async, rst_n=0): all pipeline registers, accumulators and counters are 0; pd_err=0, err_valid=0, lock=0. Reset asserted mid-pipeline discards in-flight samples, with no partial output after release.
- Pipeline: a 4-stage valid-tagged shift (v1..v4). Each stage loads only when its incoming valid is 1 and otherwise holds.
  - S1: register i_data, q_data.
  - S2: iq = I*Q (30b signed), i2 = I*I, q2 = Q*Q (29b unsigned).
  - S3: diff = i2 - q2 (30b signed); iq delayed; pow = i2 + q2 (30b unsigned).
  - S4: pd_err <= iq*diff, sign-extended to 58b.
- Width proof: |iq| <= 2^28 and |diff| <= 2^28, so |product| <= 2^56, which fits 58b signed exactly. No saturation is needed.
- Latency: data_valid at cycle N gives pd_err update and err_valid=1 at cycle N+4.
- Back-to-back valids give one result per clk. Gaps in data_valid do not flush the pipeline: every accepted sample emerges exactly once, in order.
- Lock detector, fed from S3 when v3=1:
  - acc_diff += |diff|, acc_pow += pow; both are 42b unsigned, which cannot overflow for WIN_LEN <= 4096.
  - win_cnt counts samples 0..WIN_LEN-1. On the sample where win_cnt = WIN_LEN-1, the window closes:
    - good = (acc_diff + |diff|) < ((acc_pow + pow) >> LOCK_SHIFT);
    - both accumulators restart at 0 on the next sample (the closing sample is included in the compare, not carried over);
    - win_cnt wraps to 0.
  - good_cnt (4b): increments on a good window, saturating at LOCK_WINS; clears to 0 on a bad window.
  - lock = 1 when good_cnt == LOCK_WINS. This gives asymmetric hysteresis: slow to acquire, one bad window drops lock.
  - lock changes only on the clk after a window close.
- All-zero input: pow = 0 gives threshold 0, and 0 < 0 is false, so the window is bad. Silence never reports lock.

Test Plan:
- Reset, then I=1000, Q=500 single valid: pd_err=375_000_000_000 with err_valid pulse exactly 4 clks later. Then I=500, Q=1000: pd_err=-375_000_000_000. pd_err holds for 20 idle clks.
- Extremes: I=-16384, Q=16383 gives pd_err=-8_795_287_732_224. I=Q=-16384 gives 0. I=1000, Q=0 gives 0. No overflow or sign error.
- Continuous valid with a random 15b stream, plus a stream with random data_valid gaps: pd_err sequence matches the golden model sample-for-sample, with an err_valid count equal to the input valid count.
- Lock acquire/drop: I=Q=1000 constant → lock rises 1 clk after the 4th window close (sample 4096). Then I=1000, Q=0 for one window → lock falls 1 clk after that window close.
- Lock off: all-zero input for 8 windows → lock stays 0.
- Reset mid-stream: assert rst_n low with 3 samples in flight → outputs and lock are 0 immediately. After release, no err_valid until 4 clks after the next data_valid, and window counting restarts from 0.
